// File: rtl/tft_pkg.sv
// tft_pkg: TFT controller opcodes, pixel classes, FSM states
// and the RGB888 -> panel byte packing helper.
package tft_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    PIX_BG,
    PIX_WALL,
    PIX_PLAYER
  } pix_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_PIXELS,
    ST_FIN
  } state_e;

  // bpp 2: RGB565 sent high byte first; bpp 3: R, G, B.
  function automatic logic [7:0] pack_byte(
    input logic [23:0] rgb,
    input int          bpp,
    input logic [1:0]  idx
  );
    pack_byte = 8'h00;
    if (bpp == 2) begin
      if (idx == 2'd0)
        pack_byte = {rgb[23:19], rgb[15:13]};
      else
        pack_byte = {rgb[12:10], rgb[7:3]};
    end else begin
      case (idx)
        2'd0:    pack_byte = rgb[23:16];
        2'd1:    pack_byte = rgb[15:8];
        default: pack_byte = rgb[7:0];
      endcase
    end
  endfunction

endpackage

// File: rtl/tile_pixel_classifier.sv
// tile_pixel_classifier: combinational wall/player/background
// decision for pixel (px_i,py_i) inside tile (col_i,row_i).
// Ports: tile + in-tile coords, wall bitmaps, player -> cls_o.
module tile_pixel_classifier
  import tft_pkg::*;
#(
  parameter int COLS   = 10,
  parameter int ROWS   = 15,
  parameter int TILE   = 32,
  parameter int WALL_W = 4,
  parameter int PAD    = 8,
  parameter int CW     = $clog2(COLS),
  parameter int RW     = $clog2(ROWS),
  parameter int TW     = $clog2(TILE),
  parameter int VN     = (COLS + 1) * ROWS,
  parameter int HN     = COLS * (ROWS + 1)
) (
  input  logic [CW-1:0] col_i,
  input  logic [RW-1:0] row_i,
  input  logic [TW-1:0] px_i,
  input  logic [TW-1:0] py_i,
  input  logic [VN-1:0] v_walls_i,
  input  logic [HN-1:0] h_walls_i,
  input  logic [CW-1:0] player_x_i,
  input  logic [RW-1:0] player_y_i,
  input  logic          player_en_i,
  output pix_e          cls_o
);

  localparam int VIW = $clog2(VN);
  localparam int HIW = $clog2(HN);

  logic [VIW-1:0] vl_idx;
  logic [VIW-1:0] vr_idx;
  logic [HIW-1:0] ht_idx;
  logic [HIW-1:0] hb_idx;
  logic           wall;
  logic           in_pad;
  logic           player;

  // Vertical rows hold COLS+1 segments, horizontal rows COLS.
  assign vl_idx = VIW'(32'(row_i) * 32'(COLS + 1) + 32'(col_i));
  assign vr_idx = vl_idx + VIW'(1);
  assign ht_idx = HIW'(32'(row_i) * 32'(COLS) + 32'(col_i));
  assign hb_idx = HIW'(32'(row_i) * 32'(COLS) + 32'(COLS)
                       + 32'(col_i));

  assign wall =
    (v_walls_i[vl_idx] && px_i <  TW'(WALL_W)) ||
    (v_walls_i[vr_idx] && px_i >= TW'(TILE - WALL_W)) ||
    (h_walls_i[ht_idx] && py_i <  TW'(WALL_W)) ||
    (h_walls_i[hb_idx] && py_i >= TW'(TILE - WALL_W));

  assign in_pad =
    px_i >= TW'(PAD) && px_i < TW'(TILE - PAD) &&
    py_i >= TW'(PAD) && py_i < TW'(TILE - PAD);

  assign player = player_en_i && in_pad &&
                  col_i == player_x_i && row_i == player_y_i;

  always_comb begin
    cls_o = PIX_BG;
    if (wall)
      cls_o = PIX_WALL;
    else if (player)
      cls_o = PIX_PLAYER;
  end

endmodule

// File: rtl/scene_renderer.sv
// scene_renderer: streams a maze window (full scene or one tile)
// to a byte-wide TFT driver: CASET, PASET, RAMWR, then pixels.
// Ports: start/mode/tile_x/tile_y request, live walls + player,
// tft_busy/tft_dc/tft_data/tft_transmit driver side, busy/done.
module scene_renderer
  import tft_pkg::*;
#(
  parameter int          COLS       = 10,
  parameter int          ROWS       = 15,
  parameter int          TILE       = 32,
  parameter int          WALL_W     = 4,
  parameter int          PAD        = 8,
  parameter int          BPP        = 2,
  parameter logic [23:0] WALL_RGB   = 24'h3A7BD5,
  parameter logic [23:0] PLAYER_RGB = 24'hF0D000,
  parameter logic [23:0] BG_RGB     = 24'h000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [$clog2(COLS)-1:0]      tile_x,
  input  logic [$clog2(ROWS)-1:0]      tile_y,
  input  logic [(COLS+1)*ROWS-1:0]     v_walls,
  input  logic [COLS*(ROWS+1)-1:0]     h_walls,
  input  logic [$clog2(COLS)-1:0]      player_x,
  input  logic [$clog2(ROWS)-1:0]      player_y,
  input  logic                         player_en,
  input  logic                         tft_busy,
  output logic                         tft_dc,
  output logic [7:0]                   tft_data,
  output logic                         tft_transmit,
  output logic                         busy,
  output logic                         done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(TILE);

  state_e        state_q, state_d;
  logic [2:0]    arg_q, arg_d;
  logic [1:0]    bsel_q, bsel_d;
  logic [CW-1:0] col_q, col_d, col_lo_q, col_lo_d;
  logic [CW-1:0] col_hi_q, col_hi_d;
  logic [RW-1:0] row_q, row_d, row_lo_q, row_lo_d;
  logic [RW-1:0] row_hi_q, row_hi_d;
  logic [TW-1:0] px_q, px_d, py_q, py_d;
  logic          xmit_q;
  logic          done_q, done_d;

  logic          can_send;
  logic          start_ok;
  logic [15:0]   xs, xe, ys, ye;
  pix_e          cls;
  logic [23:0]   rgb;

  function automatic logic [7:0] arg_byte(
    input logic [2:0]  i,
    input logic [7:0]  cmd,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    case (i)
      3'd0:    arg_byte = cmd;
      3'd1:    arg_byte = lo[15:8];
      3'd2:    arg_byte = lo[7:0];
      3'd3:    arg_byte = hi[15:8];
      default: arg_byte = hi[7:0];
    endcase
  endfunction

  // One byte per free driver slot; the gap after each strobe
  // covers the cycle before the driver raises tft_busy.
  assign can_send = !tft_busy && !xmit_q;

  assign start_ok = !mode ||
                    (int'(tile_x) < COLS && int'(tile_y) < ROWS);

  assign xs = 16'(32'(col_lo_q) * 32'(TILE));
  assign xe = 16'((32'(col_hi_q) + 32'd1) * 32'(TILE) - 32'd1);
  assign ys = 16'(32'(row_lo_q) * 32'(TILE));
  assign ye = 16'((32'(row_hi_q) + 32'd1) * 32'(TILE) - 32'd1);

  assign busy = (state_q != ST_IDLE) || done_q;
  assign done = done_q;

  tile_pixel_classifier #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .TILE   (TILE),
    .WALL_W (WALL_W),
    .PAD    (PAD)
  ) u_cls (
    .col_i       (col_q),
    .row_i       (row_q),
    .px_i        (px_q),
    .py_i        (py_q),
    .v_walls_i   (v_walls),
    .h_walls_i   (h_walls),
    .player_x_i  (player_x),
    .player_y_i  (player_y),
    .player_en_i (player_en),
    .cls_o       (cls)
  );

  always_comb begin
    rgb = BG_RGB;
    case (cls)
      PIX_WALL:   rgb = WALL_RGB;
      PIX_PLAYER: rgb = PLAYER_RGB;
      default:    rgb = BG_RGB;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    arg_d        = arg_q;
    bsel_d       = bsel_q;
    col_d        = col_q;
    row_d        = row_q;
    px_d         = px_q;
    py_d         = py_q;
    col_lo_d     = col_lo_q;
    col_hi_d     = col_hi_q;
    row_lo_d     = row_lo_q;
    row_hi_d     = row_hi_q;
    done_d       = 1'b0;
    tft_transmit = 1'b0;
    tft_dc       = 1'b0;
    tft_data     = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        // done_q still high means the frame is finishing.
        if (start && !done_q && start_ok) begin
          state_d  = ST_CASET;
          arg_d    = '0;
          bsel_d   = '0;
          col_lo_d = mode ? tile_x : '0;
          col_hi_d = mode ? tile_x : CW'(COLS - 1);
          row_lo_d = mode ? tile_y : '0;
          row_hi_d = mode ? tile_y : RW'(ROWS - 1);
          col_d    = col_lo_d;
          row_d    = row_lo_d;
          px_d     = '0;
          py_d     = '0;
        end
      end

      ST_CASET, ST_PASET: begin
        tft_dc   = (arg_q != 3'd0);
        tft_data = (state_q == ST_CASET)
                 ? arg_byte(arg_q, CMD_CASET, xs, xe)
                 : arg_byte(arg_q, CMD_PASET, ys, ye);
        if (can_send) begin
          tft_transmit = 1'b1;
          if (arg_q == 3'd4) begin
            arg_d   = '0;
            state_d = (state_q == ST_CASET) ? ST_PASET
                                             : ST_RAMWR;
          end else begin
            arg_d = arg_q + 3'd1;
          end
        end
      end

      ST_RAMWR: begin
        tft_data = CMD_RAMWR;
        if (can_send) begin
          tft_transmit = 1'b1;
          state_d      = ST_PIXELS;
        end
      end

      ST_PIXELS: begin
        tft_dc   = 1'b1;
        tft_data = pack_byte(rgb, BPP, bsel_q);
        if (can_send) begin
          tft_transmit = 1'b1;
          if (bsel_q != 2'(BPP - 1)) begin
            bsel_d = bsel_q + 2'd1;
          end else begin
            bsel_d = '0;
            if (px_q != TW'(TILE - 1)) begin
              px_d = px_q + TW'(1);
            end else begin
              px_d = '0;
              if (col_q != col_hi_q) begin
                col_d = col_q + CW'(1);
              end else begin
                col_d = col_lo_q;
                if (py_q != TW'(TILE - 1)) begin
                  py_d = py_q + TW'(1);
                end else begin
                  py_d = '0;
                  if (row_q != row_hi_q)
                    row_d = row_q + RW'(1);
                  else
                    state_d = ST_FIN;
                end
              end
            end
          end
        end
      end

      ST_FIN: begin
        if (!tft_busy && !xmit_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      arg_q    <= '0;
      bsel_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      col_lo_q <= '0;
      col_hi_q <= '0;
      row_lo_q <= '0;
      row_hi_q <= '0;
      xmit_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      arg_q    <= arg_d;
      bsel_q   <= bsel_d;
      col_q    <= col_d;
      row_q    <= row_d;
      px_q     <= px_d;
      py_q     <= py_d;
      col_lo_q <= col_lo_d;
      col_hi_q <= col_hi_d;
      row_lo_q <= row_lo_d;
      row_hi_q <= row_hi_d;
      xmit_q   <= tft_transmit;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_scene_renderer.sv
// tb_scene_renderer: scoreboard bench for scene_renderer.
// Instance a uses BPP=2, instance b uses BPP=3.
module tb_scene_renderer;

  localparam int COLS = 10;
  localparam int ROWS = 15;
  localparam int VN   = (COLS + 1) * ROWS;
  localparam int HN   = COLS * (ROWS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start_a, start_b, mode;
  logic [3:0]    tile_x, tile_y, player_x, player_y;
  logic [VN-1:0] v_walls;
  logic [HN-1:0] h_walls;
  logic          player_en;
  logic          tbusy_a, tbusy_b;
  logic          dc_a, tx_a, busy_a, done_a;
  logic          dc_b, tx_b, busy_b, done_b;
  logic [7:0]    data_a, data_b;

  int            checks = 0;
  int            errors = 0;
  logic [8:0]    qa[$];
  logic [8:0]    qb[$];
  int            stb_a = 0, stb_b = 0;
  int            dcnt_a = 0, dcnt_b = 0;
  logic          ptx_a = 1'b0, ptx_b = 1'b0;
  int            bc_a = 0, bc_b = 0;

  always #5 clk = ~clk;

  scene_renderer u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode),
    .tile_x(tile_x), .tile_y(tile_y),
    .v_walls(v_walls), .h_walls(h_walls),
    .player_x(player_x), .player_y(player_y),
    .player_en(player_en), .tft_busy(tbusy_a),
    .tft_dc(dc_a), .tft_data(data_a),
    .tft_transmit(tx_a), .busy(busy_a), .done(done_a)
  );

  scene_renderer #(.BPP(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode),
    .tile_x(tile_x), .tile_y(tile_y),
    .v_walls(v_walls), .h_walls(h_walls),
    .player_x(player_x), .player_y(player_y),
    .player_en(player_en), .tft_busy(tbusy_b),
    .tft_dc(dc_b), .tft_data(data_b),
    .tft_transmit(tx_b), .busy(busy_b), .done(done_b)
  );

  // Byte driver: busy for 3 cycles after each strobe.
  always @(posedge clk) begin
    if (tx_a) bc_a <= 3;
    else if (bc_a != 0) bc_a <= bc_a - 1;
    if (tx_b) bc_b <= 3;
    else if (bc_b != 0) bc_b <= bc_b - 1;
  end
  assign tbusy_a = (bc_a != 0);
  assign tbusy_b = (bc_b != 0);

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic check_byte(input bit b, input logic [8:0] got,
                            input int n);
    logic [8:0] exp;
    checks++;
    if ((b ? qb.size() : qa.size()) == 0) begin
      errors++;
      $display("FAIL byte_%s[%0d]: got %03h, expected none",
               b ? "b" : "a", n, got);
    end else begin
      if (b) exp = qb.pop_front();
      else   exp = qa.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL byte_%s[%0d]: got dc/data %03h, expected %03h",
                 b ? "b" : "a", n, got, exp);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    if (tx_a) begin
      stb_a++;
      check("handshake_a", {30'd0, tbusy_a, ptx_a}, 0);
      check_byte(1'b0, {dc_a, data_a}, stb_a);
    end
    if (tx_b) begin
      stb_b++;
      check("handshake_b", {30'd0, tbusy_b, ptx_b}, 0);
      check_byte(1'b1, {dc_b, data_b}, stb_b);
    end
    if (done_a) begin
      dcnt_a++;
      check("busy_at_done_a", busy_a, 1);
    end
    if (done_b) begin
      dcnt_b++;
      check("busy_at_done_b", busy_b, 1);
    end
    ptx_a = tx_a;
    ptx_b = tx_b;
  end

  task automatic push(input bit b, input logic dc,
                      input logic [7:0] d);
    if (b) qb.push_back({dc, d});
    else   qa.push_back({dc, d});
  endtask

  task automatic push_hdr(input bit b,
                          input logic [15:0] x0, input logic [15:0] x1,
                          input logic [15:0] y0, input logic [15:0] y1);
    push(b, 1'b0, 8'h2A);
    push(b, 1'b1, x0[15:8]); push(b, 1'b1, x0[7:0]);
    push(b, 1'b1, x1[15:8]); push(b, 1'b1, x1[7:0]);
    push(b, 1'b0, 8'h2B);
    push(b, 1'b1, y0[15:8]); push(b, 1'b1, y0[7:0]);
    push(b, 1'b1, y1[15:8]); push(b, 1'b1, y1[7:0]);
    push(b, 1'b0, 8'h2C);
  endtask

  // RGB565 pixel on instance a: wall 3B DA, background 00 00.
  task automatic px565(input bit wall);
    push(1'b0, 1'b1, wall ? 8'h3B : 8'h00);
    push(1'b0, 1'b1, wall ? 8'hDA : 8'h00);
  endtask

  task automatic pulse_start(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic finish_frame(input bit b, input string name);
    int d0;
    int n;
    d0 = b ? dcnt_b : dcnt_a;
    n  = 0;
    while ((b ? dcnt_b : dcnt_a) == d0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_time"}, n < 20000, 1);
    repeat (10) @(negedge clk);
    check({name, "_one_done"}, b ? dcnt_b : dcnt_a, d0 + 1);
    check({name, "_queue_empty"}, b ? qb.size() : qa.size(), 0);
    check({name, "_busy_low"}, b ? busy_b : busy_a, 0);
  endtask

  task automatic wait_stb_a(input int target, input string name);
    int n;
    n = 0;
    while (stb_a < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_strobes_reached"}, stb_a >= target, 1);
  endtask

  int base;
  int d0;
  logic seen_busy;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 1'b0;
    tile_x = '0; tile_y = '0; player_x = '0; player_y = '0;
    player_en = 1'b0; v_walls = '0; h_walls = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_a", tx_a, 0);
    check("rst_data_a", data_a, 0);
    check("rst_dc_a", dc_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_busy_b", busy_b, 0);
    rst = 1'b0;

    // Tile (2,3), empty maze.
    mode = 1'b1; tile_x = 4'd2; tile_y = 4'd3;
    base = stb_a;
    push_hdr(1'b0, 16'h0040, 16'h005F, 16'h0060, 16'h007F);
    for (int i = 0; i < 1024; i++) px565(1'b0);
    pulse_start(1'b0);
    check("busy_after_start", busy_a, 1);
    finish_frame(1'b0, "tile23");
    check("tile23_strobes", stb_a - base, 11 + 2048);

    // Left wall of tile (0,0) only.
    tile_x = 4'd0; tile_y = 4'd0;
    v_walls[0] = 1'b1;
    push_hdr(1'b0, 16'h0000, 16'h001F, 16'h0000, 16'h001F);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        px565(x < 4);
    pulse_start(1'b0);
    finish_frame(1'b0, "leftwall");

    // RGB888 player square at (0,0), no walls.
    v_walls = '0;
    player_en = 1'b1;
    push_hdr(1'b1, 16'h0000, 16'h001F, 16'h0000, 16'h001F);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        if (x >= 8 && x < 24 && y >= 8 && y < 24) begin
          push(1'b1, 1'b1, 8'hF0);
          push(1'b1, 1'b1, 8'hD0);
          push(1'b1, 1'b1, 8'h00);
        end else begin
          repeat (3) push(1'b1, 1'b1, 8'h00);
        end
      end
    pulse_start(1'b1);
    finish_frame(1'b1, "player888");

    // Out-of-range tiles are ignored.
    for (int k = 0; k < 2; k++) begin
      mode = 1'b1;
      tile_x = (k == 0) ? 4'd10 : 4'd0;
      tile_y = (k == 0) ? 4'd0 : 4'd15;
      base = stb_a;
      d0 = dcnt_a;
      seen_busy = 1'b0;
      pulse_start(1'b0);
      repeat (20) begin
        @(negedge clk);
        seen_busy = seen_busy | busy_a;
      end
      check("oor_no_busy", seen_busy, 0);
      check("oor_no_strobe", stb_a - base, 0);
      check("oor_no_done", dcnt_a - d0, 0);
    end

    // Tile (4,5): right + top walls, player in (5,5);
    // a second start mid-frame must be ignored.
    tile_x = 4'd4; tile_y = 4'd5;
    player_x = 4'd5; player_y = 4'd5;
    v_walls[60] = 1'b1;
    h_walls[54] = 1'b1;
    base = stb_a;
    push_hdr(1'b0, 16'h0080, 16'h009F, 16'h00A0, 16'h00BF);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        px565(x >= 28 || y < 4);
    pulse_start(1'b0);
    wait_stb_a(base + 30, "midframe");
    tile_x = 4'd1; tile_y = 4'd1; mode = 1'b0;
    pulse_start(1'b0);
    finish_frame(1'b0, "tile45");
    check("tile45_strobes", stb_a - base, 11 + 2048);

    // Full scene header, then reset after 100 strobes.
    v_walls = '0; h_walls = '0; player_en = 1'b0;
    mode = 1'b0;
    base = stb_a;
    d0 = dcnt_a;
    push_hdr(1'b0, 16'h0000, 16'h013F, 16'h0000, 16'h01DF);
    for (int i = 0; i < 89; i++) push(1'b0, 1'b1, 8'h00);
    pulse_start(1'b0);
    wait_stb_a(base + 100, "scene");
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", tx_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_strobes", stb_a - base, 100);
    check("abort_no_done", dcnt_a - d0, 0);
    check("abort_queue", qa.size(), 0);

    // Fresh start: last tile (9,14), right + bottom walls.
    mode = 1'b1; tile_x = 4'd9; tile_y = 4'd14;
    v_walls[164] = 1'b1;
    h_walls[159] = 1'b1;
    push_hdr(1'b0, 16'h0120, 16'h013F, 16'h01C0, 16'h01DF);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        px565(x >= 28 || y >= 28);
    pulse_start(1'b0);
    finish_frame(1'b0, "tile9_14");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/scene_renderer.md
SCENE_RENDERER -- requirements
Module: scene_renderer

Interface
REQ-001 Parameter COLS, 10, maze columns.
REQ-002 Parameter ROWS, 15, maze rows.
REQ-003 Parameter TILE, 32, tile edge in pixels.
REQ-004 Parameter WALL_W, 4, wall band thickness in pixels, 1..TILE/2.
REQ-005 Parameter PAD, 8, player square inset from tile edge in pixels.
REQ-006 Parameter BPP, 2, bytes per pixel: 2 = RGB565, 3 = RGB888.
REQ-007 Parameters WALL_RGB / PLAYER_RGB / BG_RGB, 24'h3A7BD5 / 24'hF0D000 / 24'h000000, 24-bit RGB888 colours.
REQ-008 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  one-cycle request; mode  in  1  0 = full scene, 1 = single tile.
REQ-010 tile_x / tile_y  in  $clog2(COLS) / $clog2(ROWS)  target tile for mode 1.
REQ-011 v_walls  in  (COLS+1)*ROWS  vertical segments; h_walls  in  COLS*(ROWS+1)  horizontal segments.
REQ-012 player_x / player_y  in  as tile_x / tile_y  player tile; player_en  in  1  draw player.
REQ-013 tft_busy  in  1  byte driver busy; tft_dc  out  1  0 = command, 1 = data.
REQ-014 tft_data  out  8  byte; tft_transmit  out  1  one-cycle send strobe.
REQ-015 busy  out  1  frame in progress; done  out  1  one-cycle completion pulse.

Function
REQ-016 States SHALL be IDLE, CASET, PASET, RAMWR, PIXELS, FIN; each of CASET/PASET sends the command byte (0x2A/0x2B, dc=0) then 4 argument bytes (start hi, start lo, end hi, end lo; dc=1); RAMWR sends 0x2C with dc=0.
REQ-017 In IDLE, start with mode=0 SHALL set window x 0..COLS*TILE-1, y 0..ROWS*TILE-1; mode=1 SHALL set x tile_x*TILE..+TILE-1, y tile_y*TILE..+TILE-1.
REQ-018 mode, tile_x, tile_y SHALL be latched at start; walls and player inputs are sampled live per pixel.
REQ-019 Start in mode 1 with tile_x>=COLS or tile_y>=ROWS SHALL be ignored (no busy, no done).
REQ-020 Start while busy=1 SHALL be ignored.
REQ-021 A byte SHALL be issued (tft_transmit=1 for one cycle, tft_data/tft_dc valid same cycle) only when tft_busy=0 and tft_transmit was 0 in the previous cycle; tft_busy is high from the cycle after the strobe until the byte completes.
REQ-022 PIXELS SHALL stream row-major, x fastest, exactly window-width x window-height pixels, BPP bytes each, dc=1.
REQ-023 Pixel (px,py) in tile (c,r) is wall if (v_walls[r*(COLS+1)+c] and px<WALL_W) or (v_walls[r*(COLS+1)+c+1] and px>=TILE-WALL_W) or (h_walls[r*COLS+c] and py<WALL_W) or (h_walls[(r+1)*COLS+c] and py>=TILE-WALL_W).
REQ-024 Else player if player_en, (c,r)=(player_x,player_y), PAD<=px,py<TILE-PAD; else background. Priority wall > player > background.
REQ-025 BPP=2 SHALL send {R[7:3],G[7:5]} then {G[4:2],B[7:3]}; BPP=3 SHALL send R, G, B.
REQ-026 After the last pixel byte's strobe, FIN SHALL wait for tft_busy=0, pulse done for one cycle, return to IDLE; busy=1 from the cycle after accepted start through the done cycle.
REQ-027 Window coordinates SHALL be computed at 16 bits; high argument byte is bits 15:8.

Reset
REQ-028 On rst: state IDLE, tft_transmit=0, tft_data=0, tft_dc=0, busy=0, done=0, all counters 0; rst mid-frame aborts with no done pulse.

Structure
REQ-029 Command opcodes (0x2A/0x2B/0x2C) and colour-packing function SHALL live in shared package tft_pkg.
REQ-030 Per-pixel classification (REQ-023/024) SHALL be sub-module tile_pixel_classifier, combinational.

Verification
REQ-031 Defaults, mode 0, tft_busy model 3 cycles -> exactly 11+307200 strobes, args 00 00 01 3F / 00 00 01 DF, one done.
REQ-032 Mode 1 tile (2,3), BPP=2 -> CASET args 00 40 00 5F, PASET 00 60 00 7F, 2048 pixel bytes, done.
REQ-033 Only left wall of (0,0), player off, mode 1 tile (0,0) -> row 0 pixels 0..3 = 0x3B,0xDA; pixel 4 = 0x00,0x00.
REQ-034 Player at (0,0), no walls, BPP=3 -> pixel (8,8) = F0,D0,00; pixel (7,8) = 00,00,00; pixel (24,8) = 00,00,00.
REQ-035 Start with tile_x=10 mode 1, and second start mid-frame -> both ignored, strobe count unchanged.
REQ-036 rst asserted after 100 strobes -> next cycle transmit=0, busy=0, no done; fresh start completes normally.
